// File: rtl/nco_phase_gen.sv
// ============================================================================
// nco_phase_gen : sample-rate NCO phase accumulator with boundary-buffered FCW
// Revision      : 1.0
// ============================================================================
`default_nettype none

module nco_phase_gen #(
  parameter int CLK_DIV     = 2500,
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   fcw_valid,
  input  logic [ACC_WIDTH-1:0]   fcw_data,
  output logic                   fcw_ready,
  input  logic                   phase_rst,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   out_valid,
  output logic                   wrap
);

  localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);

  logic [15:0]          cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] fcw_act;
  logic [ACC_WIDTH-1:0] fcw_sh;
  logic                 pending;
  logic                 rst_pend;

  logic                 tick;
  logic                 accept;
  logic [ACC_WIDTH-1:0] eff;
  logic [ACC_WIDTH:0]   sum;

  assign tick      = enable && (cnt == CNT_LAST);
  assign accept    = fcw_valid && !pending;
  assign fcw_ready = !pending;
  assign eff       = pending ? fcw_sh : fcw_act;
  assign sum       = {1'b0, acc} + {1'b0, eff};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      fcw_act   <= '0;
      fcw_sh    <= '0;
      pending   <= 1'b0;
      rst_pend  <= 1'b0;
      phase     <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      if (enable) begin
        cnt <= tick ? 16'd0 : cnt + 16'd1;
      end

      if (tick) begin
        if (pending) begin
          fcw_act <= fcw_sh;
          pending <= 1'b0;
        end
        if (rst_pend || phase_rst) begin
          acc      <= '0;
          phase    <= '0;
          wrap     <= 1'b0;
          rst_pend <= 1'b0;
        end else begin
          acc   <= sum[ACC_WIDTH-1:0];
          phase <= sum[ACC_WIDTH-1 -: PHASE_WIDTH];
          wrap  <= sum[ACC_WIDTH];
        end
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
        wrap      <= 1'b0;
        if (phase_rst) begin
          rst_pend <= 1'b1;
        end
      end

      // accept implies !pending, so this never collides with the tick-time clear
      if (accept) begin
        fcw_sh  <= fcw_data;
        pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nco_phase_gen.sv
// ============================================================================
// tb_nco_phase_gen : directed bench with a per-cycle arithmetic reference model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_nco_phase_gen;

  localparam int CD = 4;
  localparam int AW = 24;
  localparam int PW = 12;
  localparam longint MOD = 64'd1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fcw_valid = 1'b0;
  logic [AW-1:0] fcw_data = '0;
  logic          phase_rst = 1'b0;
  logic          fcw_ready;
  logic [PW-1:0] phase;
  logic          out_valid;
  logic          wrap;

  int errors = 0;
  int checks = 0;

  nco_phase_gen #(.CLK_DIV(CD), .ACC_WIDTH(AW), .PHASE_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fcw_valid(fcw_valid), .fcw_data(fcw_data), .fcw_ready(fcw_ready),
    .phase_rst(phase_rst), .phase(phase), .out_valid(out_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enabled-cycle count modulo CD gives the tick, phase is plain modular sums
  bit     m_init = 0;
  int     m_cnt;
  longint m_acc, m_act, m_sh;
  bit     m_pend, m_rstp;
  logic [PW-1:0] e_phase;
  logic   e_valid, e_wrap;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_init = 1; m_cnt = 0; m_acc = 0; m_act = 0; m_sh = 0;
      m_pend = 0; m_rstp = 0; e_phase = '0; e_valid = 0; e_wrap = 0;
    end else begin
      bit tk, acc_ok;
      longint eff, total;
      tk     = enable && (m_cnt == CD - 1);
      acc_ok = fcw_valid && !m_pend;
      if (enable) m_cnt = (m_cnt + 1) % CD;
      if (tk) begin
        eff = m_pend ? m_sh : m_act;
        if (m_pend) begin m_act = m_sh; m_pend = 0; end
        if (m_rstp || phase_rst) begin
          m_acc = 0; m_rstp = 0; e_wrap = 0;
        end else begin
          total  = m_acc + eff;
          e_wrap = (total >= MOD);
          m_acc  = total % MOD;
        end
        e_phase = PW'(m_acc / (64'd1 << (AW - PW)));
        e_valid = 1;
      end else begin
        e_valid = 0; e_wrap = 0;
        if (phase_rst) m_rstp = 1;
      end
      if (acc_ok) begin m_sh = fcw_data; m_pend = 1; end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("model_out_valid", 32'(out_valid), 32'(e_valid));
      chk("model_wrap",      32'(wrap),      32'(e_wrap));
      chk("model_phase",     32'(phase),     32'(e_phase));
      chk("model_fcw_ready", 32'(fcw_ready), 32'(!m_pend));
    end
  end

  task automatic wait_sample(output logic [PW-1:0] ph, output logic w, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 40);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL sample_timeout actual=no_out_valid required=out_valid within 40 cycles");
    end
    ph = phase; w = wrap;
  endtask

  logic [PW-1:0] ph;
  logic          w;
  int            cyc;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_phase", 32'(phase), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    chk("reset_fcw_ready", 32'(fcw_ready), 32'h1);

    // Basic stepping: FCW 0x100000 gives phase += 0x100, carry on 16th sample
    rst = 0; enable = 1; fcw_valid = 1; fcw_data = 24'h100000;
    @(negedge clk); fcw_valid = 0;
    for (int i = 1; i <= 16; i++) begin
      wait_sample(ph, w, cyc);
      chk($sformatf("step_phase_%0d", i), 32'(ph), 32'((i * 'h100) & 'hFFF));
      chk($sformatf("step_wrap_%0d", i), 32'(w), 32'(i == 16));
      if (i > 1) chk($sformatf("step_spacing_%0d", i), 32'(cyc), 32'(CD));
    end

    // Handshake: second write stalls until the tick consumes the first
    fcw_valid = 1; fcw_data = 24'h010000;
    @(negedge clk); fcw_data = 24'h200000;
    chk("hs_ready_low", 32'(fcw_ready), 32'h0);
    wait_sample(ph, w, cyc);
    chk("hs_phase_first", 32'(ph), 32'h010);
    chk("hs_ready_after_tick", 32'(fcw_ready), 32'h1);
    @(negedge clk); fcw_valid = 0;
    chk("hs_second_accepted", 32'(fcw_ready), 32'h0);
    wait_sample(ph, w, cyc);
    chk("hs_phase_second", 32'(ph), 32'h210);

    // Phase reset mid-sample
    fcw_valid = 1; fcw_data = 24'h080000;
    @(negedge clk); fcw_valid = 0;
    wait_sample(ph, w, cyc);
    chk("pr_phase_pre", 32'(ph), 32'h290);
    @(negedge clk); phase_rst = 1;
    @(negedge clk); phase_rst = 0;
    wait_sample(ph, w, cyc);
    chk("pr_phase_zero", 32'(ph), 32'h000);
    chk("pr_wrap_zero", 32'(w), 32'h0);
    wait_sample(ph, w, cyc);
    chk("pr_phase_next", 32'(ph), 32'h080);

    // Enable gating: one count elapsed, freeze 10 cycles, remaining 3 counts after
    @(negedge clk); enable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("gate_no_valid", 32'(out_valid), 32'h0);
    end
    enable = 1;
    wait_sample(ph, w, cyc);
    chk("gate_remaining", 32'(cyc), 32'd3);
    chk("gate_phase", 32'(ph), 32'h100);

    // Coincident: accept on the tick cycle uses old FCW now, new FCW next
    repeat (3) @(negedge clk);
    fcw_valid = 1; fcw_data = 24'h040000;
    @(negedge clk); fcw_valid = 0;
    chk("co_valid", 32'(out_valid), 32'h1);
    chk("co_phase_old", 32'(phase), 32'h180);
    wait_sample(ph, w, cyc);
    chk("co_phase_new", 32'(ph), 32'h1C0);

    // Mid-operation reset with pending FCW and rst_pend set
    fcw_valid = 1; fcw_data = 24'h123000;
    @(negedge clk); fcw_valid = 0; phase_rst = 1;
    @(negedge clk); phase_rst = 0; rst = 1;
    @(negedge clk);
    chk("mr_phase", 32'(phase), 32'h0);
    chk("mr_out_valid", 32'(out_valid), 32'h0);
    chk("mr_fcw_ready", 32'(fcw_ready), 32'h1);
    @(negedge clk); rst = 0;
    wait_sample(ph, w, cyc);
    chk("mr_first_cycles", 32'(cyc), 32'(CD));
    chk("mr_first_phase", 32'(ph), 32'h000);
    wait_sample(ph, w, cyc);
    chk("mr_frozen_phase", 32'(ph), 32'h000);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
